prod_acc: RTL and testbench
===========================

PROD_ACC -- requirements
Module: prod_acc

Interface
REQ-001 The block SHALL have parameter N_TERMS, default 4, meaning the number of products summed per group (legal range 1..16).
REQ-002 The block SHALL have parameter ACC_W, default 10, meaning the accumulator and result width (legal range 8..16).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 clr  input  1  synchronous group abort.
REQ-006 in_valid  input  1  in_prod is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_prod this cycle.
REQ-008 in_prod  input  8  unsigned product from the upstream 4x4 multiplier.
REQ-009 out_valid  output  1  out_sum and out_ovf are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_sum  output  ACC_W  unsigned group sum.
REQ-012 out_ovf  output  1  the group sum exceeded 2^ACC_W-1.

Function
REQ-013 The FSM SHALL have two states: ACC (collecting terms) and HOLD (presenting the result).
REQ-014 In ACC, in_ready SHALL be 1 and out_valid SHALL be 0; in HOLD, in_ready SHALL be 0 and out_valid SHALL be 1; both are decoded from the state register only.
REQ-015 An input handshake (in_valid and in_ready both 1 at an edge) SHALL add zero-extended in_prod to the accumulator and increment the term counter.
REQ-016 Idle cycles (in_valid=0) SHALL leave the accumulator, counter and state unchanged.
REQ-017 The handshake of term N_TERMS SHALL move ACC to HOLD; out_valid SHALL rise on the first cycle after that handshake (latency 1).
REQ-018 In HOLD, out_sum and out_ovf SHALL stay stable, and in_valid SHALL be ignored, until out_ready=1.
REQ-019 An output handshake SHALL clear the accumulator, counter and overflow flag and return to ACC, so in_ready=1 on the next cycle (one bubble per group).
REQ-020 out_ovf SHALL be sticky within a group: it is set by any addition whose true sum exceeds 2^ACC_W-1.
REQ-021 clr=1 SHALL clear the accumulator, counter and overflow flag and force ACC, in either state; clr SHALL take priority over simultaneous input and output handshakes, and a term offered in that cycle is dropped.
REQ-022 With N_TERMS=1, every accepted term SHALL produce a result.

Reset
REQ-023 While rst_n=0, the block SHALL be in state ACC with accumulator 0, counter 0, out_sum 0, out_ovf 0, out_valid 0 and in_ready 1, independent of clk.
REQ-024 Reset asserted mid-group or in HOLD SHALL discard the partial or pending result; no result is emitted after reset release until N_TERMS new terms are accepted.

Configuration
REQ-025 Macro PROD_ACC_SAT_EN defined: on overflow, the accumulator SHALL saturate to 2^ACC_W-1 and remain there for the rest of the group.
REQ-026 Macro PROD_ACC_SAT_EN undefined: the accumulator SHALL wrap modulo 2^ACC_W.
REQ-027 out_ovf SHALL behave identically in both builds.

Structure
REQ-028 Package prod_acc_pkg SHALL hold PROD_W=8 and the state enum type (ACC, HOLD).
REQ-029 The addition with overflow detection and optional saturation SHALL be a sub-module named prod_acc_add; the FSM, counter and registers live in prod_acc.

Verification
REQ-030 Reset: assert rst_n=0 mid-group -> out_valid=0, out_sum=0, out_ovf=0, in_ready=1 immediately (no clock edge needed).
REQ-031 Basic group: defaults, in_prod 225,225,225,225 back-to-back, out_ready=1 -> out_sum=900, out_ovf=0, out_valid high exactly one cycle after the 4th handshake.
REQ-032 Gaps and backpressure: in_prod 3,0,7,10 with idle cycles between them, out_ready=0 for 5 cycles -> out_sum=20 held stable, in_ready=0, in_valid pulses ignored, result consumed on the cycle out_ready rises.
REQ-033 Overflow: N_TERMS=8, eight terms of 225 -> out_ovf=1 and out_sum=776 without the macro, or out_sum=1023 with PROD_ACC_SAT_EN.
REQ-034 Abort: terms 50,60 followed by clr=1 in the same cycle as in_valid=1 carrying 99, then four terms of 1 -> out_sum=4, out_ovf=0.
REQ-035 Streaming: two groups back-to-back with out_ready tied to 1 -> exactly one in_ready=0 bubble between the groups, and both sums are correct.

Source files
------------

// File: rtl/prod_acc_pkg.sv
// Shared types and constants for the product accumulator.
package prod_acc_pkg;

  localparam int unsigned PROD_W = 8;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/prod_acc_add.sv
// Accumulator adder with carry-out overflow detect.
// PROD_ACC_SAT_EN: clamp the sum to all-ones on overflow instead of wrapping.
module prod_acc_add
  import prod_acc_pkg::*;
#(
  parameter int unsigned ACC_W = 10
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic [ACC_W:0] full;

  always_comb begin
    full  = {1'b0, acc_i} + (ACC_W+1)'(prod_i);
    ovf_o = full[ACC_W];
`ifdef PROD_ACC_SAT_EN
    // Once clamped, any further term overflows again, so the value sticks at max.
    sum_o = ovf_o ? '1 : full[ACC_W-1:0];
`else
    sum_o = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/prod_acc.sv
// Sums N_TERMS unsigned products per group and presents the result with a
// valid/ready handshake; PROD_ACC_SAT_EN selects saturating accumulation.
module prod_acc
  import prod_acc_pkg::*;
#(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACC_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int unsigned     CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  prod_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i  (acc_q),
    .prod_i (in_prod),
    .sum_o  (add_sum),
    .ovf_o  (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == ACC) begin
      if (in_valid) begin
        acc_d = add_sum;
        ovf_d = ovf_q | add_ovf;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = HOLD;
      end
    end else if (out_ready) begin
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_prod_acc.sv
// Directed self-checking bench for prod_acc (default and N_TERMS=8 instances).
module tb_prod_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, in_valid, out_ready;
  logic [7:0] in_prod;
  logic       in_ready, out_valid, out_ovf;
  logic [9:0] out_sum;

  logic       clr8, in_valid8, out_ready8;
  logic [7:0] in_prod8;
  logic       in_ready8, out_valid8, out_ovf8;
  logic [9:0] out_sum8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prod_acc dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  prod_acc #(.N_TERMS(8), .ACC_W(10)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_prod(in_prod8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_sum(out_sum8), .out_ovf(out_ovf8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", in_ready); end
    total++; if (out_sum !== 10'd0) begin bad++; $display("FAIL rst_sum got=%0d exp=0", out_sum); end
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_prod = 8'd100; step();
    in_prod = 8'd100; step();
    in_valid = 1'b0;
    total++; if (out_sum !== 10'd200) begin bad++; $display("FAIL rst_partial got=%0d exp=200", out_sum); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (out_sum !== 10'd0) begin bad++; $display("FAIL rst_mid_sum got=%0d exp=0", out_sum); end
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_ovf !== 1'b0) begin
      bad++; $display("FAIL rst_mid_flags got rdy=%0b vld=%0b ovf=%0b exp 1 0 0", in_ready, out_valid, out_ovf); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_prod = 8'd5; step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_after_term%0d valid got=%0b exp=0", i, out_valid); end
    end
    total++; if (out_sum !== 10'd15) begin bad++; $display("FAIL rst_after_sum got=%0d exp=15", out_sum); end
    in_prod = 8'd5; step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_sum !== 10'd20) begin
      bad++; $display("FAIL rst_after_result got vld=%0b sum=%0d exp 1 20", out_valid, out_sum); end
    out_ready = 1'b1; step();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_after_consume got=%0b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_prod = 8'd225; step();
      if (i == 2) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0b exp=0", out_valid); end
      end
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
    total++; if (out_sum !== 10'd900 || out_ovf !== 1'b0) begin
      bad++; $display("FAIL basic_sum got sum=%0d ovf=%0b exp 900 0", out_sum, out_ovf); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_hold_ready got=%0b exp=0", in_ready); end
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 10'd0) begin
      bad++; $display("FAIL basic_consume got vld=%0b rdy=%0b sum=%0d exp 0 1 0", out_valid, in_ready, out_sum); end
  endtask

  task automatic test_backpressure();
    logic [7:0] vals [4];
    vals = '{8'd3, 8'd0, 8'd7, 8'd10};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_prod = vals[i]; step();
      in_valid = 1'b0; in_prod = 8'd77;
      if (i < 3) begin
        step(); step();
        if (i == 0) begin
          total++; if (out_sum !== 10'd3) begin bad++; $display("FAIL bp_idle_sum got=%0d exp=3", out_sum); end
        end
      end
    end
    for (int c = 0; c < 5; c++) begin
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 10'd20 || out_ovf !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got vld=%0b rdy=%0b sum=%0d ovf=%0b exp 1 0 20 0",
                        c, out_valid, in_ready, out_sum, out_ovf); end
      in_valid = (c % 2 == 0); in_prod = 8'd200;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 10'd0) begin
      bad++; $display("FAIL bp_consume got vld=%0b rdy=%0b sum=%0d exp 0 1 0", out_valid, in_ready, out_sum); end
  endtask

  task automatic test_overflow();
    logic [9:0] exp_sum;
`ifdef PROD_ACC_SAT_EN
    exp_sum = 10'd1023;
`else
    exp_sum = 10'd776;
`endif
    out_ready8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid8 = 1'b1; in_prod8 = 8'd225; step();
      if (i == 3) begin
        total++; if (out_ovf8 !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b exp=0", out_ovf8); end
      end
      if (i == 4) begin
        total++; if (out_ovf8 !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b exp=1", out_ovf8); end
      end
    end
    in_valid8 = 1'b0;
    total++; if (out_valid8 !== 1'b1 || out_ovf8 !== 1'b1 || out_sum8 !== exp_sum) begin
      bad++; $display("FAIL ovf_result got vld=%0b ovf=%0b sum=%0d exp 1 1 %0d", out_valid8, out_ovf8, out_sum8, exp_sum); end
    out_ready8 = 1'b1; step();
    out_ready8 = 1'b0;
    total++; if (out_ovf8 !== 1'b0 || out_sum8 !== 10'd0 || in_ready8 !== 1'b1) begin
      bad++; $display("FAIL ovf_clear got ovf=%0b sum=%0d rdy=%0b exp 0 0 1", out_ovf8, out_sum8, in_ready8); end
  endtask

  task automatic test_abort();
    out_ready = 1'b0;
    in_valid = 1'b1; in_prod = 8'd50; step();
    in_prod = 8'd60; step();
    in_prod = 8'd99; clr = 1'b1; step();
    clr = 1'b0; in_valid = 1'b0;
    total++; if (out_sum !== 10'd0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL abort_clear got sum=%0d ovf=%0b rdy=%0b exp 0 0 1", out_sum, out_ovf, in_ready); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_prod = 8'd1; step();
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_sum !== 10'd4 || out_ovf !== 1'b0) begin
      bad++; $display("FAIL abort_result got vld=%0b sum=%0d ovf=%0b exp 1 4 0", out_valid, out_sum, out_ovf); end
    // clr wins over a simultaneous output handshake while holding
    clr = 1'b1; out_ready = 1'b1; step();
    clr = 1'b0; out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 10'd0) begin
      bad++; $display("FAIL abort_hold got vld=%0b rdy=%0b sum=%0d exp 0 1 0", out_valid, in_ready, out_sum); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [10];
    logic       exp_rdy [10];
    vals    = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd77, 8'd1, 8'd2, 8'd3, 8'd4, 8'd77};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      total++; if (in_ready !== exp_rdy[c] || out_valid !== !exp_rdy[c]) begin
        bad++; $display("FAIL b2b_cycle%0d got rdy=%0b vld=%0b exp rdy=%0b", c, in_ready, out_valid, exp_rdy[c]); end
      if (c == 4) begin
        total++; if (out_sum !== 10'd100) begin bad++; $display("FAIL b2b_sum0 got=%0d exp=100", out_sum); end
      end
      if (c == 9) begin
        total++; if (out_sum !== 10'd10) begin bad++; $display("FAIL b2b_sum1 got=%0d exp=10", out_sum); end
      end
      in_valid = 1'b1; in_prod = vals[c];
      step();
    end
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_end got rdy=%0b vld=%0b exp 1 0", in_ready, out_valid); end
    out_ready = 1'b0;
  endtask

  initial begin
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_prod = '0;
    clr8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0; in_prod8 = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
